// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response handshake bundle between a requester and the multiply/divide unit.
interface muldiv_seq_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result_lo, result_hi, div_by_zero
  );
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed/unsigned multiply (shift-add) and restoring divide, one bit per cycle.
module muldiv_seq #(
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          reset,
  muldiv_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  state_t             state_q, state_d;
  logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dbz_q, dbz_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, lo_q, lo_d, hi_q, hi_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sa, sb;
  logic [WIDTH-1:0]   ma, mb, quo, rem;
  logic [WIDTH:0]     sum, trial;
  always_comb begin
    sa      = bus.op[0] & bus.a[WIDTH-1];
    sb      = bus.op[0] & bus.b[WIDTH-1];
    ma      = sa ? -bus.a : bus.a;
    mb      = sb ? -bus.b : bus.b;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
    trial   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    prod    = neg_q ? -acc_q : acc_q;
    quo     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem     = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    state_d = state_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    a_d     = a_q;
    b_d     = b_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = BUSY;
        div_d   = bus.op[1];
        a_d     = bus.a;
        b_d     = mb;
        acc_d   = {{WIDTH{1'b0}}, ma};
        cnt_d   = CW'(WIDTH - 1);
        neg_d   = sa ^ sb;
        rneg_d  = sa;
      end
      BUSY: begin
        // trial[WIDTH] is the borrow: the remainder stays below the divisor, so no wider compare is needed
        acc_d   = div_q ? (trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1})
                        : {sum, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? FIX : BUSY;
      end
      FIX: begin
        state_d = DONE;
        lo_d    = div_q ? ((b_q == '0) ? '1 : quo) : prod[WIDTH-1:0];
        hi_d    = div_q ? ((b_q == '0) ? a_q : rem) : prod[2*WIDTH-1:WIDTH];
        dbz_d   = div_q & (b_q == '0);
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.result_lo   = lo_q;
  assign bus.result_hi   = hi_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table plus handshake, backpressure and reset sequences for muldiv_seq.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   lat;
  always #5 clk = ~clk;
  muldiv_seq_if #(.WIDTH(16)) bus ();
  muldiv_seq #(.WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b, lo, hi;
    logic        dbz;
  } vec_t;
  vec_t vecs[13];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_out(input string name);
    lat = 0;
    for (int i = 0; i < 40 && !bus.out_valid; i++) begin
      tick();
      lat++;
    end
    check({name, " latency"}, lat, 17);
  endtask
  task automatic take();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask
  task automatic check_res(input string name, input logic [15:0] lo, input logic [15:0] hi, input logic dbz);
    check({name, " lo"}, bus.result_lo, lo);
    check({name, " hi"}, bus.result_hi, hi);
    check({name, " dbz"}, bus.div_by_zero, dbz);
  endtask
  initial begin
    vecs[0]  = '{2'd0, 16'd3,    16'd55,   16'd165,  16'd0,    1'b0};
    vecs[1]  = '{2'd0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0};
    vecs[2]  = '{2'd1, 16'hFFE7, 16'd64,   16'hF9C0, 16'hFFFF, 1'b0};
    vecs[3]  = '{2'd1, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0};
    vecs[4]  = '{2'd1, 16'd7,    16'hFFFD, 16'hFFEB, 16'hFFFF, 1'b0};
    vecs[5]  = '{2'd2, 16'd666,  16'd21,   16'd31,   16'd15,   1'b0};
    vecs[6]  = '{2'd3, 16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0};
    vecs[7]  = '{2'd3, 16'd7,    16'hFFFE, 16'hFFFD, 16'd1,    1'b0};
    vecs[8]  = '{2'd3, 16'hFFF9, 16'hFFFE, 16'd3,    16'hFFFF, 1'b0};
    vecs[9]  = '{2'd2, 16'd100,  16'd0,    16'hFFFF, 16'd100,  1'b1};
    vecs[10] = '{2'd3, 16'hFFFB, 16'd0,    16'hFFFF, 16'hFFFB, 1'b1};
    vecs[11] = '{2'd3, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
    vecs[12] = '{2'd2, 16'hFFFF, 16'd16,   16'h0FFF, 16'd15,   1'b0};
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = 2'd0;
    bus.a = '0;
    bus.b = '0;
    #12;
    check("reset in_ready", bus.in_ready, 1);
    check("reset out_valid", bus.out_valid, 0);
    check_res("reset", 16'd0, 16'd0, 1'b0);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_out($sformatf("vec%0d", i));
      check_res($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi, vecs[i].dbz);
      take();
      check($sformatf("vec%0d in_ready", i), bus.in_ready, 1);
    end
    // Backpressure: DONE held for 5 cycles with stable outputs
    send(2'd2, 16'd666, 16'd21);
    wait_out("bp");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp out_valid", bus.out_valid, 1);
      check("bp in_ready", bus.in_ready, 0);
      check_res("bp", 16'd31, 16'd15, 1'b0);
    end
    take();
    // in_valid held through BUSY with different operands, then a back-to-back request
    bus.op = 2'd0;
    bus.a = 16'd3;
    bus.b = 16'd55;
    bus.in_valid = 1'b1;
    tick();
    bus.a = 16'd100;
    bus.b = 16'd100;
    wait_out("hold");
    check_res("hold", 16'd165, 16'd0, 1'b0);
    bus.a = 16'd9;
    bus.b = 16'd3;
    bus.out_ready = 1'b1;
    tick();
    check("b2b idle", bus.in_ready, 1);
    check("b2b out_valid", bus.out_valid, 0);
    tick();
    check("b2b accepted", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    wait_out("b2b");
    check_res("b2b", 16'd27, 16'd0, 1'b0);
    take();
    // Reset at iteration 8 of a divide
    send(2'd2, 16'd666, 16'd21);
    for (int i = 0; i < 8; i++) tick();
    #2;
    reset = 1'b0;
    #1;
    check("rst out_valid", bus.out_valid, 0);
    check("rst in_ready", bus.in_ready, 1);
    check_res("rst", 16'd0, 16'd0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid || !bus.in_ready) check("rst idle", {bus.out_valid, bus.in_ready}, 2'b01);
    end
    check("post-rst in_ready", bus.in_ready, 1);
    send(2'd0, 16'd9, 16'd3);
    wait_out("post-rst");
    check_res("post-rst", 16'd27, 16'd0, 1'b0);
    take();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
